// File: rtl/rf_burst_reader_pkg.sv
// Shared types for the register-file burst reader.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rf_burst_pkg;

    // Default register-file address width; depth is 2**ADDR_WIDTH.
    localparam int unsigned RF_DEFAULT_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of words addressable with an address of the given width.
    function automatic int unsigned rf_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/rf_burst_reader_if.sv
// Command, register-file read port and output stream bundle for the burst reader.
// Latency: none (wires only).
// Backpressure: m_ready from the consumer throttles the stream.
interface rf_burst_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rf_r_addr;
    logic [DATA_WIDTH-1:0] rf_r_data;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    // The burst reader itself.
    modport slave (
        input  start, base_addr, len, rf_r_data, m_ready,
        output busy, done, rf_r_addr, m_data, m_valid, m_last
    );

    // Whoever commands the reader and consumes its stream.
    modport master (
        output start, base_addr, len, rf_r_data, m_ready,
        input  busy, done, rf_r_addr, m_data, m_valid, m_last
    );
endinterface

// File: rtl/rf_burst_reader_out_stage.sv
// Output register of the burst stream: data, valid and last flag.
// Latency: one cycle from load_i to the registered outputs.
// Backpressure: holds its word while valid and not accepted; the parent only loads when free.
module rf_out_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  accept_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o
);
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_valid_q;
    logic                  m_last_q;

    // A load captures a new word; an accept without a load empties the stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (load_i) begin
            m_data_q  <= data_i;
            m_valid_q <= 1'b1;
            m_last_q  <= last_i;
        end else if (accept_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;
endmodule

// File: rtl/rf_burst_reader.sv
// Walks a wrapping address range of a register file and streams the words out.
// Latency: first word valid one cycle after the start is taken, then one word per cycle.
// Backpressure: m_ready low freezes the output word and the address walk.
module rf_burst_reader
    import rf_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = RF_DEFAULT_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_burst_reader_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH + 1)'(rf_depth(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0] REM_ONE   = (ADDR_WIDTH + 1)'(1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] rf_r_addr_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  load;
    logic                  accept;
    logic                  last_word;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;

    // A word is captured whenever the output register is free or being emptied.
    assign load      = (state_q == READ) && (!m_valid || bus.m_ready);
    assign accept    = (state_q == DRAIN) && m_valid && bus.m_ready;
    assign last_word = (rem_q == REM_ONE);
    // Lengths beyond the register-file depth would re-read words; cap at one full sweep.
    assign len_clamped = (bus.len > DEPTH_LEN) ? DEPTH_LEN : bus.len;

    // Burst sequencing, address walk and remaining-word count.
    // done is registered off the DONE state, so DONE holds for a second cycle
    // while the pulse is on the output, then returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rf_r_addr_q <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            rf_r_addr_q <= bus.base_addr;
                            rem_q       <= len_clamped;
                            state_q     <= READ;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                READ: begin
                    if (load) begin
                        rf_r_addr_q <= rf_r_addr_q + 1'b1;
                        rem_q       <= rem_q - 1'b1;
                        if (last_word) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    rf_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .accept_i  (accept),
        .data_i    (bus.rf_r_data),
        .last_i    (last_word),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_last_o  (m_last)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rf_r_addr = rf_r_addr_q;
    assign bus.m_data    = m_data;
    assign bus.m_valid   = m_valid;
    assign bus.m_last    = m_last;
endmodule

// File: tb/tb_rf_burst_reader.sv
// Bench for rf_burst_reader: directed and random bursts against a queue-based model.
// Latency: checks first-word, done and idle cycles when the consumer never stalls.
// Backpressure: drives fixed and random m_ready patterns and checks stall stability.
module tb_rf_burst_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_burst_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    rf_burst_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file model: asynchronous read, write visible after the edge.
    logic [7:0] mem [16];
    logic [7:0] init_mem [16];
    logic [7:0] model_mem [16];
    logic       load_mem = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign bus.rf_r_data = mem[bus.rf_r_addr];

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_memory();
        for (int i = 0; i < 16; i++) init_mem[i] = model_mem[i];
        load_mem = 1'b1;
        @(posedge clk); #1;
        load_mem = 1'b0;
    endtask

    // mode 0: ready always 1; 1: fixed pattern 1,0,0,1,0,1,1,1 then 1; 2: random.
    // wr_k >= 0: write 8'h55 to the address loaded at the edge after cycle wr_k.
    task automatic run_burst(input logic [3:0] base, input int len, input int mode,
                             input int wr_k, input bit inject_start);
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic [7:0] pat;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       ready;
        bit         prev_stall;
        bit         idle_seen;
        int         done_cnt, done_c, first_v, n_words, c;

        pat = 8'b1110_1001;
        for (int i = 0; i < len; i++) exp_q.push_back(model_mem[(base + i) % 16]);

        bus.base_addr = base;
        bus.len       = len[4:0];
        bus.m_ready   = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        if (len > 0) chk("first_addr", bus.rf_r_addr, base);

        done_cnt = 0; done_c = -1; first_v = -1; n_words = 0;
        idle_seen = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        for (c = 0; c < 300; c++) begin
            if (c > 0 && !bus.busy) begin
                idle_seen = 1;
                break;
            end
            if (prev_stall) begin
                chk("stall_valid", bus.m_valid, 1);
                chk("stall_data", bus.m_data, prev_data);
                chk("stall_last", bus.m_last, prev_last);
            end
            if (bus.done) begin
                done_cnt++;
                done_c = c;
            end
            if (bus.m_valid && first_v < 0) first_v = c;
            if (len == 0) chk("len0_no_valid", bus.m_valid, 0);

            case (mode)
                0:       ready = 1'b1;
                1:       ready = (c < 8) ? pat[c] : 1'b1;
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            bus.m_ready = ready;

            if (inject_start && (c == 1 || c == 2)) begin
                bus.start     = 1'b1;
                bus.base_addr = 4'd9;
                bus.len       = 5'd3;
            end else begin
                bus.start = 1'b0;
            end

            if (c == wr_k) begin
                wr_en   = 1'b1;
                wr_addr = 4'((base + c) % 16);
                wr_data = 8'h55;
            end else begin
                wr_en = 1'b0;
            end

            if (bus.m_valid && bus.m_ready) begin
                n_words++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("data", bus.m_data, e);
                    chk("last", bus.m_last, exp_q.size() == 0);
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        wr_en     = 1'b0;

        chk("idle_reached", idle_seen, 1);
        chk("word_count", n_words, len);
        chk("done_pulses", done_cnt, 1);
        if (mode == 0) begin
            chk("done_cycle", done_c, (len == 0) ? 1 : len + 2);
            chk("idle_cycle", c, (len == 0) ? 2 : len + 3);
            if (len > 0) chk("first_valid", first_v, 1);
        end
        @(posedge clk); #1;
        chk("no_queued_start", bus.busy, 0);
        if (wr_k >= 0) model_mem[(base + wr_k) % 16] = 8'h55;
    endtask

    initial begin
        int done_seen;
        int busy_seen;

        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.m_ready   = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_addr", bus.rf_r_addr, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) model_mem[i] = 8'hA0 + 8'(i);
        load_memory();

        run_burst(4'd3, 4, 0, -1, 0);
        run_burst(4'd14, 4, 0, -1, 0);
        run_burst(4'd0, 6, 1, -1, 0);
        run_burst(4'd0, 0, 0, -1, 0);
        run_burst(4'd4, 5, 0, -1, 1);

        // Reset in the middle of a burst abandons it silently.
        bus.base_addr = 4'd2;
        bus.len       = 5'd10;
        bus.m_ready   = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_valid_before_rst", bus.m_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_addr", bus.rf_r_addr, 0);
        chk("mid_rst_data", bus.m_data, 0);
        chk("mid_rst_valid", bus.m_valid, 0);
        chk("mid_rst_last", bus.m_last, 0);
        rst_n = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
            if (bus.busy || bus.m_valid) busy_seen++;
        end
        chk("post_rst_no_done", done_seen, 0);
        chk("post_rst_idle", busy_seen, 0);

        // Full sweep with a same-edge write to the address being loaded.
        run_burst(4'd5, 16, 0, 3, 0);
        run_burst(4'd8, 1, 0, -1, 0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) model_mem[i] = 8'($urandom);
            load_memory();
            run_burst(4'($urandom_range(0, 15)), int'($urandom_range(0, 16)), 2, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
